// File: rtl/anton_neopixel_registers_dbuf.sv
// Double-buffered pixel memory plus control/IRQ registers for the NeoPixel controller.
// The bus writes and reads the back bank; the stream engine reads the front bank.
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 255
`endif

module anton_neopixel_registers_dbuf #(
  parameter int BUFFER_END  = `BUFFER_END_DEFAULT,
  parameter int ADDR_BITS   = 14,
  parameter int BUFFER_BITS = $clog2(BUFFER_END + 1)
) (
  input  logic                   busClk,
  input  logic                   busReset,
  input  logic [ADDR_BITS-1:0]   busAddr,
  input  logic [7:0]             busDataIn,
  input  logic                   busWrite,
  input  logic                   busRead,
  output logic [7:0]             busDataOut,
  output logic                   busReady,
  input  logic                   streamSyncOf,
  input  logic                   syncStart,
  input  logic                   state,
  input  logic [BUFFER_BITS-1:0] streamAddr,
  output logic [7:0]             streamData,
  output logic [12:0]            regMax,
  output logic                   regCtrlInit,
  output logic                   regCtrlLimit,
  output logic                   regCtrlRun,
  output logic                   regCtrlLoop,
  output logic                   regCtrl32bit,
  output logic                   initSlow,
  input  logic                   initSlowDone,
  output logic                   irq
);

  localparam int DEPTH = BUFFER_END + 1;

  logic [7:0] bank0_mem [DEPTH];
  logic [7:0] bank1_mem [DEPTH];

  logic [12:0] reg_max_q, reg_max_d;
  logic        ctrl_init_q, ctrl_init_d;
  logic        ctrl_limit_q, ctrl_limit_d;
  logic        ctrl_run_q, ctrl_run_d;
  logic        ctrl_loop_q, ctrl_loop_d;
  logic        ctrl_32bit_q, ctrl_32bit_d;
  logic [1:0]  irq_status_q, irq_status_d;
  logic [1:0]  irq_en_q, irq_en_d;
  logic        bank_sel_q, bank_sel_d;
  logic        swap_pending_q, swap_pending_d;
  logic        init_slow_q, init_slow_d;
  logic [7:0]  bus_data_out_q, bus_data_out_d;
  logic        bus_ready_q, bus_ready_d;
  logic [7:0]  stream_data_q, stream_data_d;

  logic                   reg_sel;
  logic [2:0]             reg_idx;
  logic [ADDR_BITS-2:0]   pix_idx;
  logic [BUFFER_BITS-1:0] pix_addr;
  logic                   pix_in_range;
  logic                   stream_in_range;
  logic                   bus_wr_reg;
  logic                   bus_wr_pix;
  logic                   bank0_we;
  logic                   bank1_we;
  logic [7:0]             back_data;
  logic [7:0]             front_data;
  logic [7:0]             rd_data;

  assign reg_sel         = busAddr[ADDR_BITS-1];
  assign reg_idx         = busAddr[2:0];
  assign pix_idx         = busAddr[ADDR_BITS-2:0];
  assign pix_addr        = pix_idx[BUFFER_BITS-1:0];
  assign pix_in_range    = (pix_idx <= (ADDR_BITS-1)'(BUFFER_END));
  assign stream_in_range = ({1'b0, streamAddr} <= (BUFFER_BITS+1)'(BUFFER_END));

  // bank_sel_q names the front bank, so pixel writes land in the other one
  assign bus_wr_reg = busWrite && reg_sel && !busReset;
  assign bus_wr_pix = busWrite && !reg_sel && pix_in_range && !busReset;
  assign bank0_we   = bus_wr_pix && bank_sel_q;
  assign bank1_we   = bus_wr_pix && !bank_sel_q;

  always_ff @(posedge busClk) begin
    if (bank0_we) bank0_mem[pix_addr] <= busDataIn;
    if (bank1_we) bank1_mem[pix_addr] <= busDataIn;
  end

  always_comb begin
    back_data  = 8'h00;
    front_data = 8'h00;
    if (pix_in_range)
      back_data = bank_sel_q ? bank0_mem[pix_addr] : bank1_mem[pix_addr];
    if (stream_in_range)
      front_data = bank_sel_q ? bank1_mem[streamAddr] : bank0_mem[streamAddr];
  end

  always_comb begin
    rd_data = 8'h00;
    if (reg_sel) begin
      case (reg_idx)
        3'd0:    rd_data = reg_max_q[7:0];
        3'd1:    rd_data = {3'b000, reg_max_q[12:8]};
        3'd2:    rd_data = {3'b000, ctrl_32bit_q, ctrl_loop_q, ctrl_run_q,
                            ctrl_limit_q, ctrl_init_q};
        3'd3:    rd_data = {7'b0, state};
        3'd4:    rd_data = {6'b0, irq_status_q};
        3'd5:    rd_data = {6'b0, irq_en_q};
        3'd6:    rd_data = {6'b0, bank_sel_q, swap_pending_q};
        default: rd_data = 8'h00;
      endcase
    end else begin
      rd_data = back_data;
    end
  end

  // Hardware events first, bus register writes last so they win collisions
  always_comb begin
    reg_max_d      = reg_max_q;
    ctrl_init_d    = ctrl_init_q;
    ctrl_limit_d   = ctrl_limit_q;
    ctrl_run_d     = ctrl_run_q;
    ctrl_loop_d    = ctrl_loop_q;
    ctrl_32bit_d   = ctrl_32bit_q;
    irq_en_d       = irq_en_q;
    bank_sel_d     = bank_sel_q;
    swap_pending_d = swap_pending_q;
    init_slow_d    = init_slow_q;

    if (swap_pending_q && (streamSyncOf || !ctrl_run_q)) begin
      bank_sel_d     = !bank_sel_q;
      swap_pending_d = 1'b0;
    end
    if (streamSyncOf) ctrl_run_d = ctrl_loop_q;
    if (syncStart)    ctrl_run_d = 1'b1;

    if (ctrl_init_q) begin
      ctrl_limit_d   = 1'b0;
      ctrl_run_d     = 1'b0;
      ctrl_loop_d    = 1'b0;
      ctrl_32bit_d   = 1'b0;
      swap_pending_d = 1'b0;
      bank_sel_d     = 1'b0;
      init_slow_d    = 1'b1;
    end
    if (initSlowDone) begin
      ctrl_init_d = 1'b0;
      init_slow_d = 1'b0;
    end

    // A status set arriving with a W1C of the same bit keeps the bit set
    irq_status_d = irq_status_q;
    if (bus_wr_reg && (reg_idx == 3'd4))
      irq_status_d = irq_status_q & ~busDataIn[1:0];
    irq_status_d = irq_status_d | {initSlowDone, streamSyncOf};

    if (bus_wr_reg) begin
      case (reg_idx)
        3'd0: reg_max_d[7:0]  = busDataIn;
        3'd1: reg_max_d[12:8] = busDataIn[4:0];
        3'd2: {ctrl_32bit_d, ctrl_loop_d, ctrl_run_d, ctrl_limit_d, ctrl_init_d} = busDataIn[4:0];
        3'd5: irq_en_d = busDataIn[1:0];
        3'd6: if (busDataIn[0]) swap_pending_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_data_out_d = busRead ? rd_data : bus_data_out_q;
    bus_ready_d    = busRead;
    stream_data_d  = front_data;
  end

  always_ff @(posedge busClk) begin
    if (busReset) begin
      reg_max_q      <= 13'h0;
      ctrl_init_q    <= 1'b0;
      ctrl_limit_q   <= 1'b0;
      ctrl_run_q     <= 1'b0;
      ctrl_loop_q    <= 1'b0;
      ctrl_32bit_q   <= 1'b0;
      irq_status_q   <= 2'b00;
      irq_en_q       <= 2'b00;
      bank_sel_q     <= 1'b0;
      swap_pending_q <= 1'b0;
      init_slow_q    <= 1'b0;
      bus_data_out_q <= 8'h00;
      bus_ready_q    <= 1'b0;
      stream_data_q  <= 8'h00;
    end else begin
      reg_max_q      <= reg_max_d;
      ctrl_init_q    <= ctrl_init_d;
      ctrl_limit_q   <= ctrl_limit_d;
      ctrl_run_q     <= ctrl_run_d;
      ctrl_loop_q    <= ctrl_loop_d;
      ctrl_32bit_q   <= ctrl_32bit_d;
      irq_status_q   <= irq_status_d;
      irq_en_q       <= irq_en_d;
      bank_sel_q     <= bank_sel_d;
      swap_pending_q <= swap_pending_d;
      init_slow_q    <= init_slow_d;
      bus_data_out_q <= bus_data_out_d;
      bus_ready_q    <= bus_ready_d;
      stream_data_q  <= stream_data_d;
    end
  end

  assign busDataOut   = bus_data_out_q;
  assign busReady     = bus_ready_q;
  assign streamData   = stream_data_q;
  assign regMax       = reg_max_q;
  assign regCtrlInit  = ctrl_init_q;
  assign regCtrlLimit = ctrl_limit_q;
  assign regCtrlRun   = ctrl_run_q;
  assign regCtrlLoop  = ctrl_loop_q;
  assign regCtrl32bit = ctrl_32bit_q;
  assign initSlow     = init_slow_q;
  assign irq          = |(irq_status_q & irq_en_q);

endmodule
